unxorer: RTL and testbench

Streaming decoder that inverts the xorer running transform in the sm_test example system. Each input beat is an encoded word plus its 4-bit lane parameter; the block recovers the original data word using d = (e − lp) XOR e_prev, where e_prev is the previously accepted encoded word. It sits downstream of xorer as the receive-side checker/decoder and uses the same valid/ready stream handshake on both sides. The block is a 2-stage pipeline with a single global stall.

---
 rtl/unxorer_pkg.sv | 9 +
 rtl/unxorer_checker.sv | 42 ++++
 rtl/unxorer.sv | 97 +++++++++
 tb/tb_unxorer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/unxorer_pkg.sv
// Shared constants for the unxorer stream decoder and its optional output checker.
package unxorer_pkg;

    localparam int LP_WIDTH        = 4;
    localparam int ERR_COUNT_WIDTH = 16;

    localparam logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_MAX = '1;

endpackage : unxorer_pkg

// File: rtl/unxorer_checker.sv
// Output checker: compares each delivered word against a free-running expected counter.
// Compiled only when UNXORER_CHECK_EN is defined.
`ifdef UNXORER_CHECK_EN
module unxorer_checker
    import unxorer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hs,
    input  logic [WIDTH-1:0]           data,
    output logic                       err,
    output logic [ERR_COUNT_WIDTH-1:0] err_count
);

    logic [WIDTH-1:0] exp_data;
    logic             mismatch;

    assign mismatch = hs && (data != exp_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_data  <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (hs) begin
                exp_data <= exp_data + WIDTH'(1);
            end
            if (mismatch) begin
                err <= 1'b1;
                // Saturate rather than wrap so a long-running failure never reads as clean.
                if (err_count != ERR_COUNT_MAX) begin
                    err_count <= err_count + ERR_COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule : unxorer_checker
`endif

// File: rtl/unxorer.sv
// Two-stage streaming decoder undoing the xorer transform: d = (e - lp) ^ e_prev.
// Optional output checker (o_err, o_err_count) enabled by defining UNXORER_CHECK_EN.
module unxorer
    import unxorer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_data,
    input  logic [LP_WIDTH-1:0]        i_lp,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data
`ifdef UNXORER_CHECK_EN
    ,
    output logic                       o_err,
    output logic [ERR_COUNT_WIDTH-1:0] o_err_count
`endif
);

    logic             en;
    logic             acc;
    logic [WIDTH-1:0] lp_ext;
    logic [WIDTH-1:0] prev;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_diff;
    logic [WIDTH-1:0] s1_prev;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;

    // A single global stall: the pipe only freezes when the output beat is blocked.
    assign en      = !(s2_valid && !i_ready);
    assign o_ready = en;
    assign acc     = i_valid && en;

    // Size cast zero-extends for wide words and truncates when WIDTH < LP_WIDTH.
    assign lp_ext = WIDTH'(i_lp);

    // NOTE: every register here uses non-blocking assignment and the async reset
    // clears data as well as valids, so a mid-stream reset leaves no stale words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else if (acc) begin
            prev <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_prev  <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_diff <= i_data - lp_ext;
                // prev still holds the previous beat here; its update lands on the same edge.
                s1_prev <= prev;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_diff ^ s1_prev;
            end
        end
    end

    assign o_valid = s2_valid;
    assign o_data  = s2_data;

`ifdef UNXORER_CHECK_EN
    unxorer_checker #(
        .WIDTH(WIDTH)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .hs        (s2_valid && i_ready),
        .data      (s2_data),
        .err       (o_err),
        .err_count (o_err_count)
    );
`endif

endmodule : unxorer

// File: tb/tb_unxorer.sv
// Directed scoreboard bench for unxorer (WIDTH=8); checker scenario runs when UNXORER_CHECK_EN is defined.
module tb_unxorer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic [3:0]  i_lp;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
`ifdef UNXORER_CHECK_EN
    logic        o_err;
    logic [15:0] o_err_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    logic [7:0]  prev_m;
    logic        last_acc;

    unxorer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_lp        (i_lp),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data)
`ifdef UNXORER_CHECK_EN
        ,
        .o_err       (o_err),
        .o_err_count (o_err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [7:0] exp_v;
        @(negedge clk);
        if (o_valid && i_ready) begin
            check("sb_not_empty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                check("sb_data", 32'(o_data), 32'(exp_v));
            end
        end
        last_acc = i_valid && o_ready;
        if (last_acc) begin
            sb.push_back((i_data - {4'b0, i_lp}) ^ prev_m);
            prev_m = i_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [3:0] lp);
        i_valid = 1'b1;
        i_data  = d;
        i_lp    = lp;
    endtask

    task automatic beat(input logic [7:0] d, input logic [3:0] lp);
        drive(d, lp);
        last_acc = 1'b0;
        for (int n = 0; n < 20 && !last_acc; n++) tick();
        check("beat_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        reset   = 1'b1;
        #1;
        sb.delete();
        prev_m = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] enc_prev;
        logic [7:0] enc;

        reset   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = 8'h00;
        i_lp    = 4'h0;
        prev_m  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data",  32'(o_data),  32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
`ifdef UNXORER_CHECK_EN
        check("rst_o_err",       32'(o_err),       32'd0);
        check("rst_o_err_count", 32'(o_err_count), 32'd0);
`endif
        reset = 1'b0;

        // Basic decode and two-cycle latency.
        drive(8'h08, 4'd3);
        tick();
        check("lat_not_yet", 32'(o_valid), 32'd0);
        drive(8'h03, 4'd1);
        tick();
        check("basic0_valid", 32'(o_valid), 32'd1);
        check("basic0_data",  32'(o_data),  32'h05);
        i_valid = 1'b0;
        tick();
        check("basic1_valid", 32'(o_valid), 32'd1);
        check("basic1_data",  32'(o_data),  32'h0A);
        tick();
        check("basic_idle", 32'(o_valid), 32'd0);
        drain();

        // Subtraction wraps modulo 256.
        do_reset();
        drive(8'h01, 4'd4);
        tick();
        i_valid = 1'b0;
        tick();
        check("wrap_valid", 32'(o_valid), 32'd1);
        check("wrap_data",  32'(o_data),  32'hFD);
        drain();

        // Backpressure: output held, input blocked, nothing lost or duplicated.
        do_reset();
        beat(8'h11, 4'd1);
        beat(8'h22, 4'd2);
        i_ready = 1'b0;
        drive(8'h33, 4'd3);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_o_ready", 32'(o_ready), 32'd0);
            check("bp_o_valid", 32'(o_valid), 32'd1);
            check("bp_o_data",  32'(o_data),  32'(sb[0]));
            tick();
        end
        i_ready = 1'b1;
        beat(8'h33, 4'd3);
        beat(8'h44, 4'd4);
        drain();

        // Bubble in the middle: valids follow 1,0,1 and the bubble leaves prev alone.
        do_reset();
        drive(8'h10, 4'd2);
        tick();
        i_data  = 8'hAA;
        i_lp    = 4'd5;
        i_valid = 1'b0;
        tick();
        check("bub_v0", 32'(o_valid), 32'd1);
        drive(8'h20, 4'd1);
        tick();
        check("bub_v1", 32'(o_valid), 32'd0);
        i_valid = 1'b0;
        tick();
        check("bub_v2",    32'(o_valid), 32'd1);
        check("bub_data2", 32'(o_data),  32'h0F);
        drain();

        // Reset with both stages full.
        do_reset();
        drive(8'h55, 4'd5);
        tick();
        drive(8'h66, 4'd6);
        tick();
        i_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check("mid_rst_o_valid", 32'(o_valid), 32'd0);
        check("mid_rst_o_data",  32'(o_data),  32'd0);
        sb.delete();
        prev_m = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        beat(8'h07, 4'd0);
        i_valid = 1'b0;
        tick();
        check("post_rst_valid", 32'(o_valid), 32'd1);
        check("post_rst_data",  32'(o_data),  32'h07);
        drain();

`ifdef UNXORER_CHECK_EN
        // Checker: xorer-encoded 0..3 are clean, a corrupted fifth word is flagged once.
        do_reset();
        enc_prev = 8'h00;
        for (int d = 0; d < 4; d++) begin
            enc = (8'(d) ^ enc_prev) + 8'd2;
            enc_prev = enc;
            beat(enc, 4'd2);
        end
        drain();
        check("chk_clean_err",   32'(o_err),       32'd0);
        check("chk_clean_count", 32'(o_err_count), 32'd0);
        enc = ((8'd4 ^ enc_prev) + 8'd2) ^ 8'h40;
        beat(enc, 4'd2);
        drain();
        check("chk_bad_err",   32'(o_err),       32'd1);
        check("chk_bad_count", 32'(o_err_count), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_unxorer
